// File: rtl/uart_prog_loader_pkg.sv
// uart_prog_loader_pkg: shared constants, status codes and loader state encoding.
package uart_prog_loader_pkg;
  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  typedef enum logic [1:0] {ST_OK = 2'd0, ST_FRAME = 2'd1, ST_LEN = 2'd2, ST_CHK = 2'd3} status_t;
  typedef enum logic [1:0] {IDLE, COUNT, DATA, CHECK} state_t;
endpackage

// File: rtl/uart_prog_loader_uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchronizer, false-start rejection and stop-bit check.
module uart_rx #(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] rx_byte,
  output logic       byte_valid,
  output logic       frame_err
);
  localparam int CPB = CLK_HZ / BAUD;
  localparam int CW  = $clog2(CPB + 1);
  typedef enum logic [1:0] {R_IDLE, R_START, R_BITS, R_STOP} rstate_t;
  rstate_t rstate_q, rstate_d;
  logic [2:0] sync_q, sync_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0] bit_q, bit_d;
  logic [7:0] shreg_q, shreg_d;
  logic valid_q, valid_d, ferr_q, ferr_d;
  logic rx_s;
  // sync_q[1] is the synchronized line, sync_q[2] its previous value for edge detection
  assign rx_s = sync_q[1];
  always_comb begin
    sync_d = {sync_q[1:0], rx};
    rstate_d = rstate_q;
    cnt_d = cnt_q + CW'(1);
    bit_d = bit_q;
    shreg_d = shreg_q;
    valid_d = 1'b0;
    ferr_d = 1'b0;
    case (rstate_q)
      R_IDLE: begin
        cnt_d = '0;
        if (!rx_s && sync_q[2]) rstate_d = R_START;
      end
      R_START: if (cnt_q == CW'(CPB / 2 - 1)) begin
        cnt_d = '0;
        bit_d = '0;
        rstate_d = rx_s ? R_IDLE : R_BITS;
      end
      R_BITS: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        shreg_d = {rx_s, shreg_q[7:1]};
        bit_d = bit_q + 3'd1;
        if (bit_q == 3'd7) rstate_d = R_STOP;
      end
      R_STOP: if (cnt_q == CW'(CPB - 1)) begin
        cnt_d = '0;
        valid_d = rx_s;
        ferr_d = !rx_s;
        rstate_d = R_IDLE;
      end
      default: rstate_d = R_IDLE;
    endcase
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rstate_q <= R_IDLE;
      sync_q <= 3'b111;
      cnt_q <= '0;
      bit_q <= '0;
      shreg_q <= '0;
      valid_q <= 1'b0;
      ferr_q <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      sync_q <= sync_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      shreg_q <= shreg_d;
      valid_q <= valid_d;
      ferr_q <= ferr_d;
    end
  end
  assign rx_byte = shreg_q;
  assign byte_valid = valid_q;
  assign frame_err = ferr_q;
endmodule

// File: rtl/uart_prog_loader.sv
// uart_prog_loader: parses A5/N/data/checksum frames from UART and writes big-endian words to instruction memory.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int CLK_HZ = 50000000,
  parameter int BAUD   = 115200,
  parameter int ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx,
  output logic              wr_en,
  output logic [ADDR_W+1:0] wr_addr,
  output logic [31:0]       wr_data,
  output logic              loading,
  output logic              done,
  output logic [1:0]        status
);
  logic [7:0] rx_byte;
  logic byte_valid, frame_err;
  uart_rx #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) u_rx (
    .clock(clock), .reset(reset), .rx(rx),
    .rx_byte(rx_byte), .byte_valid(byte_valid), .frame_err(frame_err)
  );
  state_t state_q, state_d;
  status_t status_q, status_d;
  logic [ADDR_W:0] cnt_q, cnt_d, idx_q, idx_d;
  logic [1:0] bcnt_q, bcnt_d;
  logic [31:0] shift_q, shift_d, wr_data_q, wr_data_d;
  logic [7:0] acc_q, acc_d;
  logic [ADDR_W+1:0] wr_addr_q, wr_addr_d;
  logic wr_en_q, wr_en_d, done_q, done_d;
  always_comb begin
    state_d = state_q;
    status_d = status_q;
    cnt_d = cnt_q;
    idx_d = idx_q;
    bcnt_d = bcnt_q;
    shift_d = shift_q;
    acc_d = acc_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    wr_en_d = 1'b0;
    done_d = 1'b0;
    if (frame_err && state_q != IDLE) begin
      status_d = ST_FRAME;
      state_d = IDLE;
    end else if (byte_valid) begin
      case (state_q)
        IDLE: if (rx_byte == SYNC_BYTE) begin
          state_d = COUNT;
          status_d = ST_OK;
        end
        COUNT: begin
          cnt_d = (ADDR_W + 1)'(rx_byte);
          idx_d = '0;
          bcnt_d = '0;
          acc_d = '0;
          if (int'(rx_byte) > (1 << ADDR_W)) begin
            status_d = ST_LEN;
            state_d = IDLE;
          end else state_d = (rx_byte == 8'd0) ? CHECK : DATA;
        end
        DATA: begin
          shift_d = {shift_q[23:0], rx_byte};
          acc_d = acc_q ^ rx_byte;
          bcnt_d = bcnt_q + 2'd1;
          if (bcnt_q == 2'd3) begin
            wr_en_d = 1'b1;
            wr_addr_d = {idx_q[ADDR_W-1:0], 2'b00};
            wr_data_d = shift_d;
            idx_d = idx_q + (ADDR_W + 1)'(1);
            if (idx_d == cnt_q) state_d = CHECK;
          end
        end
        CHECK: begin
          done_d = (rx_byte == acc_q);
          status_d = (rx_byte == acc_q) ? status_q : ST_CHK;
          state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      status_q <= ST_OK;
      cnt_q <= '0;
      idx_q <= '0;
      bcnt_q <= '0;
      shift_q <= '0;
      acc_q <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_en_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state_q <= state_d;
      status_q <= status_d;
      cnt_q <= cnt_d;
      idx_q <= idx_d;
      bcnt_q <= bcnt_d;
      shift_q <= shift_d;
      acc_q <= acc_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      wr_en_q <= wr_en_d;
      done_q <= done_d;
    end
  end
  assign wr_en = wr_en_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign done = done_q;
  assign status = status_q;
  assign loading = (state_q != IDLE);
endmodule

// File: tb/tb_uart_prog_loader.sv
// tb_uart_prog_loader: directed frames with a scoreboard queue of expected writes and done pulses.
module tb_uart_prog_loader;
  localparam int CPB = 10;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1;
  logic wr_en, loading, done;
  logic [6:0] wr_addr;
  logic [31:0] wr_data;
  logic [1:0] status;
  int total = 0, bad = 0;
  typedef struct {bit is_done; logic [6:0] addr; logic [31:0] data;} ev_t;
  ev_t exp_q[$];
  logic [7:0] bq[$];

  uart_prog_loader #(.CLK_HZ(1000), .BAUD(100), .ADDR_W(5)) dut (
    .clock(clk), .reset(reset), .rx(rx), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .loading(loading), .done(done), .status(status)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic push_wr(input logic [6:0] a, input logic [31:0] d);
    ev_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic push_done();
    ev_t e;
    e.is_done = 1'b1; e.addr = '0; e.data = '0;
    exp_q.push_back(e);
  endtask

  task automatic hold(input logic v, input int n);
    rx = v;
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    hold(1'b0, CPB);
    for (int i = 0; i < 8; i++) hold(b[i], CPB);
    hold(stop, CPB);
    hold(1'b1, CPB);
  endtask

  task automatic send_q();
    foreach (bq[i]) send_byte(bq[i], 1'b1);
  endtask

  task automatic settle(input string tag, input logic [1:0] st);
    repeat (5) @(negedge clk);
    chk({tag, "_status"}, 32'(status), 32'(st));
    chk({tag, "_loading"}, 32'(loading), 32'd0);
    chk({tag, "_pending"}, exp_q.size(), 32'd0);
  endtask

  initial forever begin
    @(negedge clk);
    if (!reset && (wr_en || done)) begin
      if (exp_q.size() == 0) chk("spurious_out", {30'd0, wr_en, done}, 32'd0);
      else begin
        ev_t e;
        e = exp_q.pop_front();
        if (e.is_done) chk("done_evt", {30'd0, wr_en, done}, 32'd1);
        else begin
          chk("wr_evt", {30'd0, wr_en, done}, 32'd2);
          chk("wr_addr", 32'(wr_addr), 32'(e.addr));
          chk("wr_data", wr_data, e.data);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_outs", {wr_en, loading, done, status, wr_addr}, 32'd0);
    chk("rst_data", wr_data, 32'd0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // good frame; XOR of the eight data bytes is 0x66
    push_wr(7'd0, 32'h11223344); push_wr(7'd4, 32'hDEADBEEF); push_done();
    bq = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    send_q();
    chk("loading_mid", 32'(loading), 32'd1);
    send_byte(8'h66, 1'b1);
    settle("good", 2'd0);

    push_wr(7'd0, 32'h11223344); push_wr(7'd4, 32'hDEADBEEF);
    send_q();
    send_byte(8'h00, 1'b1);
    settle("badchk", 2'd3);

    bq = '{8'hA5, 8'h02, 8'h11, 8'h22};
    send_q();
    reset = 1'b1;
    #1;
    chk("midrst_outs", {wr_en, loading, done, status, wr_addr}, 32'd0);
    chk("midrst_data", wr_data, 32'd0);
    repeat (4) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    push_wr(7'd0, 32'h11223344); push_wr(7'd4, 32'hDEADBEEF); push_done();
    bq = '{8'hA5, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66};
    send_q();
    settle("postrst", 2'd0);

    bq = '{8'hA5, 8'h21};
    send_q();
    settle("len", 2'd2);

    bq = '{8'hA5, 8'h02, 8'h11, 8'h22};
    send_q();
    send_byte(8'h33, 1'b0);
    bq = '{8'h44, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h66};
    send_q();
    settle("frame", 2'd1);
    push_wr(7'd0, 32'h12345678); push_done();
    bq = '{8'hA5, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h08};
    send_q();
    settle("recover", 2'd0);

    hold(1'b0, 3);
    hold(1'b1, 3 * CPB);
    chk("glitch_loading", 32'(loading), 32'd0);
    chk("glitch_pending", exp_q.size(), 32'd0);
    bq = '{8'h00, 8'hFF};
    send_q();
    chk("noise_loading", 32'(loading), 32'd0);
    push_wr(7'd0, 32'hCAFEBABE); push_done();
    bq = '{8'hA5, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE, 8'h30};
    send_q();
    settle("noise", 2'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
